// File: rtl/picorv32_mem_pkg.sv
// rtl/picorv32_mem_pkg.sv - shared types and constants for the picorv32 memory responder
package picorv32_mem_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  // Returned on mem_rdata for writes, out-of-range accesses and idle cycles
  localparam logic [DATA_W-1:0] ERR_FILL = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } mem_state_t;

endpackage

// File: rtl/picorv32_mem_ram.sv
// rtl/picorv32_mem_ram.sv - single-port word RAM with byte enables and registered read
module picorv32_mem_ram
  import picorv32_mem_pkg::*;
#(
  parameter int MEM_WORDS = 1024
) (
  input  logic                         clk,
  input  logic                         re,
  input  logic [STRB_W-1:0]            we,
  input  logic [$clog2(MEM_WORDS)-1:0] addr,
  input  logic [DATA_W-1:0]            wdata,
  output logic [DATA_W-1:0]            rdata
);

  logic [DATA_W-1:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < STRB_W; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/picorv32_mem_responder.sv
// rtl/picorv32_mem_responder.sv - picorv32 native-interface memory slave with wait states and range errors
module picorv32_mem_responder
  import picorv32_mem_pkg::*;
#(
  parameter int                MEM_WORDS   = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter int                WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  input  logic              mem_instr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [STRB_W-1:0] mem_wstrb,
  output logic              mem_ready,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_err,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count,
  output logic [31:0]       if_count
);

  localparam int                AW        = $clog2(MEM_WORDS);
  localparam logic [ADDR_W-1:0] SPAN      = ADDR_W'(MEM_WORDS * 4);
  localparam logic [3:0]        WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  mem_state_t state, state_nxt;

  logic [AW-1:0]     word_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              instr_q;
  logic              in_range_q;
  logic [3:0]        wait_cnt;

  logic              accept;
  logic              enter_resp;
  logic [ADDR_W-1:0] offset;
  logic              req_in_range;
  logic [STRB_W-1:0] cur_wstrb;
  logic              cur_in_range;
  logic              ram_re;
  logic [STRB_W-1:0] ram_we;
  logic [AW-1:0]     ram_addr;
  logic [DATA_W-1:0] ram_rdata;

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mem_valid) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_nxt  = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = ST_WAIT;
          end
        end
      end
      // Losing mem_valid here, including on the last wait cycle, drops the request silently
      ST_WAIT: begin
        if (!mem_valid) begin
          state_nxt = ST_IDLE;
        end else if (wait_cnt == 4'd0) begin
          state_nxt  = ST_RESP;
          enter_resp = 1'b1;
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Unsigned wrap makes addresses below BASE_ADDR fall out of range as well
  assign offset       = mem_addr - BASE_ADDR;
  assign req_in_range = (offset < SPAN);

  // With no wait states RESP is entered straight from IDLE, so the read uses the live request
  assign cur_wstrb    = (state == ST_IDLE) ? mem_wstrb : wstrb_q;
  assign cur_in_range = (state == ST_IDLE) ? req_in_range : in_range_q;
  assign ram_addr     = (state == ST_IDLE) ? mem_addr[AW+1:2] : word_q;
  assign ram_re       = enter_resp && (cur_wstrb == '0) && cur_in_range && !reset;
  assign ram_we       = (state == ST_RESP && in_range_q && !reset) ? wstrb_q : '0;

  picorv32_mem_ram #(
    .MEM_WORDS(MEM_WORDS)
  ) u_ram (
    .clk  (clk),
    .re   (ram_re),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

  assign mem_ready = (state == ST_RESP);
  assign mem_err   = (state == ST_RESP) && !in_range_q;
  assign mem_rdata = (state == ST_RESP && in_range_q && wstrb_q == '0) ? ram_rdata : ERR_FILL;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      word_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      instr_q    <= 1'b0;
      in_range_q <= 1'b0;
      wait_cnt   <= 4'd0;
      rd_count   <= 32'd0;
      wr_count   <= 32'd0;
      if_count   <= 32'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        word_q     <= mem_addr[AW+1:2];
        wdata_q    <= mem_wdata;
        wstrb_q    <= mem_wstrb;
        instr_q    <= mem_instr;
        in_range_q <= req_in_range;
        wait_cnt   <= WAIT_LOAD;
      end else if (state == ST_WAIT && mem_valid && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (state == ST_RESP) begin
        if (wstrb_q == '0) begin
          rd_count <= rd_count + 32'd1;
          if (instr_q) if_count <= if_count + 32'd1;
        end else begin
          wr_count <= wr_count + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_picorv32_mem_responder.sv
// tb/tb_picorv32_mem_responder.sv - scoreboard bench over three responders with 0, 2 and 3 wait states
module tb_picorv32_mem_responder;

  localparam int NDUT = 3;
  localparam int WC[NDUT] = '{0, 2, 3};

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid [NDUT];
  logic        mem_instr [NDUT];
  logic [31:0] mem_addr  [NDUT];
  logic [31:0] mem_wdata [NDUT];
  logic [3:0]  mem_wstrb [NDUT];
  logic        mem_ready [NDUT];
  logic [31:0] mem_rdata [NDUT];
  logic        mem_err   [NDUT];
  logic [31:0] rd_count  [NDUT];
  logic [31:0] wr_count  [NDUT];
  logic [31:0] if_count  [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    picorv32_mem_responder #(
      .MEM_WORDS  (1024),
      .BASE_ADDR  (32'h0000_0000),
      .WAIT_CYCLES(WC[g])
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .mem_valid(mem_valid[g]),
      .mem_instr(mem_instr[g]),
      .mem_addr (mem_addr[g]),
      .mem_wdata(mem_wdata[g]),
      .mem_wstrb(mem_wstrb[g]),
      .mem_ready(mem_ready[g]),
      .mem_rdata(mem_rdata[g]),
      .mem_err  (mem_err[g]),
      .rd_count (rd_count[g]),
      .wr_count (wr_count[g]),
      .if_count (if_count[g])
    );
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sbq [NDUT][$];
  logic [31:0] model [NDUT][1024];
  int unsigned exp_rd [NDUT];
  int unsigned exp_wr [NDUT];
  int unsigned exp_if [NDUT];
  int          checks = 0;
  int          errors = 0;

  task automatic push_exp(input int d, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input logic instr);
    exp_t       e;
    logic       in_rng;
    logic [9:0] w;
    in_rng  = (addr < 32'h0000_1000);
    w       = addr[11:2];
    e.err   = !in_rng;
    e.rdata = 32'h0;
    if (wstrb == 4'b0000) begin
      if (in_rng) e.rdata = model[d][w];
      exp_rd[d]++;
      if (instr) exp_if[d]++;
    end else begin
      exp_wr[d]++;
      if (in_rng)
        for (int b = 0; b < 4; b++)
          if (wstrb[b]) model[d][w][8*b +: 8] = wdata[8*b +: 8];
    end
    sbq[d].push_back(e);
  endtask

  task automatic wait_resp(input int d, input string name, output int lat);
    exp_t e;
    bit   got;
    got = 0;
    lat = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      if (mem_ready[d] === 1'b1) got = 1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s: dut%0d gave no mem_ready within %0d cycles", name, d, lat);
      if (sbq[d].size() > 0) void'(sbq[d].pop_front());
    end else begin
      e = sbq[d].pop_front();
      if (mem_rdata[d] !== e.rdata || mem_err[d] !== e.err) begin
        errors++;
        $display("FAIL %s: dut%0d rdata=%h err=%b, required rdata=%h err=%b",
                 name, d, mem_rdata[d], mem_err[d], e.rdata, e.err);
      end
    end
  endtask

  task automatic drive(input int d, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input logic instr);
    mem_valid[d] = 1'b1;
    mem_addr[d]  = addr;
    mem_wdata[d] = wdata;
    mem_wstrb[d] = wstrb;
    mem_instr[d] = instr;
  endtask

  task automatic txn(input int d, input string name, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] wstrb, input logic instr);
    int lat;
    @(negedge clk);
    drive(d, addr, wdata, wstrb, instr);
    push_exp(d, addr, wdata, wstrb, instr);
    wait_resp(d, name, lat);
    mem_valid[d] = 1'b0;
    mem_instr[d] = 1'b0;
    checks++;
    if (lat != WC[d] + 1) begin
      errors++;
      $display("FAIL %s latency: dut%0d took %0d cycles, required %0d", name, d, lat, WC[d] + 1);
    end
    @(posedge clk); #1;
    checks++;
    if (mem_ready[d] !== 1'b0) begin
      errors++;
      $display("FAIL %s pulse: dut%0d mem_ready=%b one cycle later, required 0", name, d, mem_ready[d]);
    end
  endtask

  task automatic check_counts(input int d, input string name);
    checks++;
    if (rd_count[d] !== exp_rd[d] || wr_count[d] !== exp_wr[d] || if_count[d] !== exp_if[d]) begin
      errors++;
      $display("FAIL %s counts: dut%0d rd=%0d wr=%0d if=%0d, required rd=%0d wr=%0d if=%0d",
               name, d, rd_count[d], wr_count[d], if_count[d], exp_rd[d], exp_wr[d], exp_if[d]);
    end
  endtask

  task automatic check_quiet(input int d, input string name, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (mem_ready[d] !== 1'b0 || mem_err[d] !== 1'b0 || mem_rdata[d] !== 32'h0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL %s quiet: dut%0d showed a response on %0d cycles, required 0", name, d, seen);
    end
  endtask

  task automatic clear_expected_counts();
    for (int d = 0; d < NDUT; d++) begin
      exp_rd[d] = 0;
      exp_wr[d] = 0;
      exp_if[d] = 0;
    end
  endtask

  task automatic test_reset();
    int n;
    bit seen [NDUT];
    @(negedge clk);
    reset = 1'b1;
    clear_expected_counts();
    for (int d = 0; d < NDUT; d++) begin
      drive(d, 32'h0000_2000, 32'h0, 4'b0000, 1'b0);
      seen[d] = 0;
    end
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      for (int d = 0; d < NDUT; d++) begin
        checks++;
        if (mem_ready[d] !== 1'b0 || mem_err[d] !== 1'b0 || mem_rdata[d] !== 32'h0) begin
          errors++;
          $display("FAIL reset outputs: dut%0d ready=%b err=%b rdata=%h, required 0/0/0",
                   d, mem_ready[d], mem_err[d], mem_rdata[d]);
        end
        check_counts(d, "reset");
      end
    end
    for (int d = 0; d < NDUT; d++) push_exp(d, 32'h0000_2000, 32'h0, 4'b0000, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      n++;
      for (int d = 0; d < NDUT; d++) begin
        if (!seen[d] && mem_ready[d] === 1'b1) begin
          exp_t e;
          seen[d]      = 1;
          mem_valid[d] = 1'b0;
          e = sbq[d].pop_front();
          checks++;
          if (n != WC[d] + 1 || mem_err[d] !== e.err || mem_rdata[d] !== e.rdata) begin
            errors++;
            $display("FAIL reset first response: dut%0d at %0d err=%b rdata=%h, required at %0d err=%b rdata=%h",
                     d, n, mem_err[d], mem_rdata[d], WC[d] + 1, e.err, e.rdata);
          end
        end
      end
    end
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (!seen[d]) begin
        errors++;
        $display("FAIL reset release: dut%0d produced no mem_ready, required one", d);
        void'(sbq[d].pop_front());
      end
      check_counts(d, "after reset");
    end
  endtask

  task automatic test_byte_write();
    txn(0, "preload w4", 32'h0000_0010, 32'h1122_3344, 4'b1111, 1'b0);
    txn(0, "byte write", 32'h0000_0010, 32'hAABB_CCDD, 4'b0011, 1'b0);
    txn(0, "byte readback", 32'h0000_0010, 32'h0, 4'b0000, 1'b0);
    txn(0, "high bytes", 32'h0000_0010, 32'h99EE_0000, 4'b1100, 1'b0);
    txn(0, "low addr bits ignored", 32'h0000_0013, 32'h0, 4'b0000, 1'b0);
    check_counts(0, "byte write");
  endtask

  task automatic test_wait_states();
    txn(2, "wait write", 32'h0000_0040, 32'h0F1E_2D3C, 4'b1111, 1'b0);
    txn(2, "wait read", 32'h0000_0040, 32'h0, 4'b0000, 1'b0);
    txn(1, "wait2 write", 32'h0000_0044, 32'h7788_99AA, 4'b1111, 1'b0);
    txn(1, "wait2 read", 32'h0000_0044, 32'h0, 4'b0000, 1'b0);
    check_counts(2, "wait states");
  endtask

  task automatic test_out_of_range();
    txn(0, "preload w0", 32'h0000_0000, 32'hCAFE_F00D, 4'b1111, 1'b0);
    txn(0, "oor read", 32'h0000_1000, 32'h0, 4'b0000, 1'b0);
    txn(0, "oor write", 32'h0000_1000, 32'h1234_5678, 4'b1111, 1'b0);
    txn(0, "w0 after oor write", 32'h0000_0000, 32'h0, 4'b0000, 1'b0);
    txn(0, "last word write", 32'h0000_0FFC, 32'h5A5A_0001, 4'b1111, 1'b0);
    txn(0, "last word read", 32'h0000_0FFC, 32'h0, 4'b0000, 1'b0);
    txn(0, "top of space", 32'hFFFF_FFFC, 32'h0, 4'b0000, 1'b1);
    check_counts(0, "out of range");
  endtask

  task automatic test_abort();
    txn(1, "abort preload", 32'h0000_0008, 32'h0BAD_BEEF, 4'b1111, 1'b0);
    @(negedge clk);
    drive(1, 32'h0000_0008, 32'hFFFF_FFFF, 4'b1111, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    mem_valid[1] = 1'b0;
    check_quiet(1, "abort in wait", 6);
    check_counts(1, "abort");
    txn(1, "abort readback", 32'h0000_0008, 32'h0, 4'b0000, 1'b0);
    txn(2, "late abort preload", 32'h0000_0008, 32'h6655_4433, 4'b1111, 1'b0);
    @(negedge clk);
    drive(2, 32'h0000_0008, 32'h0000_0000, 4'b1111, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    mem_valid[2] = 1'b0;
    check_quiet(2, "abort at resp entry", 6);
    txn(2, "late abort readback", 32'h0000_0008, 32'h0, 4'b0000, 1'b0);
    check_counts(2, "late abort");
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    drive(2, 32'h0000_0040, 32'hDEAD_DEAD, 4'b1111, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (mem_ready[2] !== 1'b0) begin
      errors++;
      $display("FAIL midflight reset: mem_ready=%b, required 0", mem_ready[2]);
    end
    @(negedge clk);
    reset        = 1'b0;
    mem_valid[2] = 1'b0;
    clear_expected_counts();
    check_quiet(2, "after midflight reset", 6);
    for (int d = 0; d < NDUT; d++) check_counts(d, "midflight reset");
    txn(2, "ram kept through reset", 32'h0000_0040, 32'h0, 4'b0000, 1'b0);
  endtask

  task automatic test_back_to_back();
    int lat;
    for (int d = 0; d < NDUT; d++) begin
      for (int k = 0; k < 3; k++)
        txn(d, "b2b preload", 32'(k * 4), 32'h1000_0000 * (k + 1) + 32'(d), 4'b1111, 1'b0);
      @(negedge clk);
      drive(d, 32'h0000_0000, 32'h0, 4'b0000, 1'b1);
      push_exp(d, 32'h0000_0000, 32'h0, 4'b0000, 1'b1);
      for (int k = 0; k < 3; k++) begin
        wait_resp(d, "b2b fetch", lat);
        if (k > 0) begin
          checks++;
          if (lat != WC[d] + 2) begin
            errors++;
            $display("FAIL b2b spacing: dut%0d %0d cycles, required %0d", d, lat, WC[d] + 2);
          end
        end
        if (k < 2) begin
          mem_addr[d] = 32'((k + 1) * 4);
          push_exp(d, mem_addr[d], 32'h0, 4'b0000, 1'b1);
        end else begin
          mem_valid[d] = 1'b0;
          mem_instr[d] = 1'b0;
        end
      end
      @(posedge clk); #1;
      check_counts(d, "back to back");
    end
  endtask

  initial begin
    reset = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      mem_valid[d] = 1'b0;
      mem_instr[d] = 1'b0;
      mem_addr[d]  = 32'h0;
      mem_wdata[d] = 32'h0;
      mem_wstrb[d] = 4'h0;
    end
    test_reset();
    test_byte_write();
    test_wait_states();
    test_out_of_range();
    test_abort();
    test_reset_midflight();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
